idecode: RTL
============

IDECODE -- requirements
Module: idecode

Interface
REQ-001 Parameter NO_WB_BYPASS, default 0, meaning: 0 forwards a same-cycle write-back into the read data, 1 returns the stored register value.
REQ-002 clk  in  1  single rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 InstrD, PCD, PCPlus4D  in  32 each  decode-stage instruction, PC and PC+4 from the IF/ID register.
REQ-005 RegWriteW  in  1; RdW  in  5; ResultW  in  32  write-back enable, destination and data.
REQ-006 FlushE  in  1  inserts a bubble into the ID/EX register.
REQ-007 Rs1D, Rs2D  out  5 each  combinational source indices for the hazard unit.
REQ-008 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE  out  1 each  registered controls.
REQ-009 ResultSrcE  out  2; ALUControlE  out  3; Funct3E  out  3  registered controls.
REQ-010 RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each; Rs1E, Rs2E, RdE  out  5 each  registered data.

Function
REQ-011 The decode shall take Rs1D=InstrD[19:15], Rs2D=InstrD[24:20] and RdD=InstrD[11:7].
REQ-012 The register file shall hold 32x32 registers, and x0 shall always read 0.
REQ-013 The register file shall write on the rising clk edge when RegWriteW=1 and RdW!=0.
REQ-014 When NO_WB_BYPASS=0, RegWriteW=1 and RdW equals a nonzero source index, the read data for that source shall be ResultW in the same cycle.
REQ-015 The decoder shall produce these controls (RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump):
- lw 0000011: 1, I, 1, 0, 01, 0, 00, 0.
- sw 0100011: 0, S, 1, 1, xx, 0, 00, 0.
- R-type 0110011: 1, x, 0, 0, 00, 0, 10, 0.
- beq 1100011: 0, B, 0, 0, xx, 1, 01, 0.
- I-ALU 0010011: 1, I, 1, 0, 00, 0, 10, 0.
- jal 1101111: 1, J, x, 0, 10, 0, xx, 1.
REQ-016 Any other opcode shall force all enables to 0 and set IllegalE=1 in the registered stage; don't-care fields shall be driven to 0.
REQ-017 ALUControl shall be:
- ALUOp 00 gives add 000; ALUOp 01 gives sub 001.
- ALUOp 10 with funct3 000 gives sub 001 when {op[5],funct7[5]}=11, otherwise add 000.
- ALUOp 10 with funct3 010 gives slt 101, 110 gives or 011, 111 gives and 010, and any other funct3 gives 000.
REQ-018 The immediate (ImmExt) shall be sign-extended from InstrD[31] for all formats:
- I: Instr[31:20].
- S: {Instr[31:25], Instr[11:7]}.
- B: {Instr[7], Instr[30:25], Instr[11:8], 0}.
- J: {Instr[19:12], Instr[20], Instr[30:21], 0}.
REQ-019 The ID/EX register shall capture all decoded fields on every rising edge, giving a latency of exactly 1 cycle from ID to E; there is no stall input.
REQ-020 When FlushE=1 at an edge, every E output shall load 0, including IllegalE.
REQ-021 When FlushE=1 and RegWriteW=1 occur in the same cycle, the register-file write shall still occur.
REQ-022 Funct3E shall carry InstrD[14:12] for branch and memory-width use downstream.

Reset
REQ-023 While reset=0, all E outputs and all 32 registers shall be 0, asynchronously.
REQ-024 A reset asserted mid-operation shall discard any write-back in progress, and the first edge after release shall capture the current InstrD.

Structure
REQ-025 The opcode constants, ALUControl encodings, ALUOp encodings and the ImmSrc enum (I, S, B, J) shall live in the shared package riscv_pkg.
REQ-026 The register file shall be the sub-module regfile, with two asynchronous read ports, one synchronous write port and the REQ-014 bypass.
REQ-027 The decoder, ALU decoder and immediate extender shall remain combinational logic inside idecode.

Verification
REQ-028 Reset: hold reset=0, then release with InstrD=32'h00000013 -> all outputs 0 during reset, then RegWriteE=1, ALUSrcE=1 and ImmExtE=0 after one edge.
REQ-029 Write-back bypass: RegWriteW=1, RdW=5, ResultW=32'hDEADBEEF with InstrD=add x6,x5,x0 (32'h00028333) in the same cycle -> RD1E=32'hDEADBEEF after the edge; with NO_WB_BYPASS=1 -> RD1E=0.
REQ-030 x0 protection: write RdW=0 with ResultW=32'h1234, then read x0 -> RD1E=0.
REQ-031 Immediate sign extension:
- beq with offset -8 (32'hFE000CE3) -> ImmExtE=32'hFFFFFFF8, BranchE=1.
- jal with offset +2048 -> ImmExtE=32'h00000800, JumpE=1, ResultSrcE=10.
REQ-032 Flush: lw instruction present with FlushE=1 -> all E outputs 0 after the edge; a concurrent write to x7 is still readable in the next cycle.
REQ-033 Illegal opcode: InstrD=32'hFFFFFFFF -> IllegalE=1, RegWriteE=0, MemWriteE=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, immediate formats and the ID/EX register bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    // Major opcodes understood by the decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALUControl encodings seen by the execute stage
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALUOp: main decoder -> ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // Everything the ID/EX register carries into the execute stage
    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic        illegal;
        logic [1:0]  result_src;
        logic [2:0]  alu_control;
        logic [2:0]  funct3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } idex_t;

endpackage

// File: rtl/regfile.sv
// 32x32 register file, x0 hard-wired to zero, optional write-back forwarding.
// Latency: reads combinational; write lands on the rising clk edge.
// Backpressure: none; a write is accepted on every edge it is presented.
module regfile #(
    parameter int unsigned NO_WB_BYPASS = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [32];

    // Storage: cleared by reset, x0 is never written so it stays zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    // Read ports: x0 reads zero, a same-cycle write-back is forwarded unless disabled
    always_comb begin
        rd1 = regs[a1];
        rd2 = regs[a2];
        if (a1 == 5'd0) rd1 = '0;
        else if (NO_WB_BYPASS == 0 && we && wa == a1) rd1 = wd;
        if (a2 == 5'd0) rd2 = '0;
        else if (NO_WB_BYPASS == 0 && we && wa == a2) rd2 = wd;
    end

endmodule

// File: rtl/idecode.sv
// RV32I decode stage: field split, control decode, immediate extend, regfile read, ID/EX register.
// Latency: exactly one clk from InstrD to the E outputs; Rs1D/Rs2D are combinational.
// Backpressure: none; no stall, FlushE loads a bubble (all-zero) into ID/EX.
module idecode
    import riscv_pkg::*;
#(
    parameter int unsigned NO_WB_BYPASS = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic        IllegalE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [2:0]  Funct3E,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE
);

    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [4:0]  rd;
    logic        reg_write, mem_write, jump, branch, alu_src, illegal;
    logic [1:0]  result_src, alu_op;
    logic [2:0]  alu_control;
    imm_src_e    imm_src;
    logic [31:0] imm_ext, rd1, rd2;
    idex_t       idex_d, idex_q;

    assign op        = InstrD[6:0];
    assign funct3    = InstrD[14:12];
    assign funct7_b5 = InstrD[30];
    assign rd        = InstrD[11:7];
    assign Rs1D      = InstrD[19:15];
    assign Rs2D      = InstrD[24:20];

    regfile #(.NO_WB_BYPASS(NO_WB_BYPASS)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .a1    (Rs1D),
        .a2    (Rs2D),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (RegWriteW),
        .wa    (RdW),
        .wd    (ResultW)
    );

    // Main decoder: don't-care fields are tied to 0, unknown opcodes flag illegal
    always_comb begin
        reg_write  = 1'b0;
        imm_src    = IMM_I;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        result_src = 2'b00;
        branch     = 1'b0;
        alu_op     = ALUOP_ADD;
        jump       = 1'b0;
        illegal    = 1'b0;
        case (op)
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'b01;
            end
            OP_STORE: begin
                imm_src   = IMM_S;
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_RTYPE: begin
                reg_write = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                imm_src = IMM_B;
                branch  = 1'b1;
                alu_op  = ALUOP_SUB;
            end
            OP_IALU: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                imm_src    = IMM_J;
                result_src = 2'b10;
                jump       = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // ALU decoder: sub only for R-type with funct7[5]; addi with imm[10] set stays add
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = ({op[5], funct7_b5} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    // Immediate extender: every format sign-extends from InstrD[31]
    always_comb begin
        imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
        case (imm_src)
            IMM_S: imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J: imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
        endcase
    end

    // Gather the decoded fields into the ID/EX bundle
    always_comb begin
        idex_d             = '0;
        idex_d.reg_write   = reg_write;
        idex_d.mem_write   = mem_write;
        idex_d.jump        = jump;
        idex_d.branch      = branch;
        idex_d.alu_src     = alu_src;
        idex_d.illegal     = illegal;
        idex_d.result_src  = result_src;
        idex_d.alu_control = alu_control;
        idex_d.funct3      = funct3;
        idex_d.rd1         = rd1;
        idex_d.rd2         = rd2;
        idex_d.imm         = imm_ext;
        idex_d.pc          = PCD;
        idex_d.pc_plus4    = PCPlus4D;
        idex_d.rs1         = Rs1D;
        idex_d.rs2         = Rs2D;
        idex_d.rd          = rd;
    end

    // ID/EX register: captures every edge, flush inserts an all-zero bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      idex_q <= '0;
        else if (FlushE) idex_q <= '0;
        else             idex_q <= idex_d;
    end

    assign RegWriteE   = idex_q.reg_write;
    assign MemWriteE   = idex_q.mem_write;
    assign JumpE       = idex_q.jump;
    assign BranchE     = idex_q.branch;
    assign ALUSrcE     = idex_q.alu_src;
    assign IllegalE    = idex_q.illegal;
    assign ResultSrcE  = idex_q.result_src;
    assign ALUControlE = idex_q.alu_control;
    assign Funct3E     = idex_q.funct3;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc_plus4;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;
    assign RdE         = idex_q.rd;

endmodule
